output_accum_buffer: RTL and testbench

- Parametrised output-feature-map store for the delta convolution datapath; sits after the per-input-channel multiplier arrays.
- Each input-channel port delivers a product plane tagged with (output channel, kernel row, kernel col). The block shifts the plane by the kernel offset and either overwrites or saturating-accumulates it into the addressed output map.
- Adds round-robin arbitration across channel ports and a read-and-clear streaming drain with valid/ready.

---
 rtl/output_accum_buffer.sv | 166 ++++++++++++++++
 tb/tb_output_accum_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_accum_buffer.sv
// output_accum_buffer: shifted overwrite/saturating-accumulate store for output maps with round-robin ports and a read-and-clear drain
module output_accum_buffer #(
  parameter int IN_CH = 2,
  parameter int OUT_CH = 4,
  parameter int IN_H = 6,
  parameter int IN_W = 6,
  parameter int K_H = 3,
  parameter int K_W = 3,
  parameter int DATA_W = 16,
  parameter int KW_LOG = 2,
  parameter int KH_LOG = 2,
  parameter int OC_LOG = 2,
  localparam int IDX_W = OC_LOG + KH_LOG + KW_LOG,
  localparam int OUT_H = IN_H - K_H + 1,
  localparam int OUT_W = IN_W - K_W + 1,
  localparam int RW = OUT_H > 1 ? $clog2(OUT_H) : 1,
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [IN_CH-1:0]                  req_valid,
  output logic [IN_CH-1:0]                  req_ready,
  input  logic [IN_CH-1:0]                  req_acc,
  input  logic [IN_CH*IDX_W-1:0]            req_idx,
  input  logic [IN_CH*IN_H*IN_W*DATA_W-1:0] req_plane,
  input  logic                              drain_start,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [OC_LOG-1:0]                 out_ch,
  output logic [RW-1:0]                     out_row,
  output logic [CW-1:0]                     out_col,
  output logic                              out_last,
  output logic                              err
);
  localparam int PW = IN_CH > 1 ? $clog2(IN_CH) : 1;
  localparam int TOTAL = OUT_CH * OUT_H * OUT_W;

  typedef enum logic {ACCEPT, DRAIN} state_t;

  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [OC_LOG-1:0] ch_q, ch_d, nch;
  logic [RW-1:0] row_q, row_d, nrow;
  logic [CW-1:0] col_q, col_d, ncol;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, err_q, err_d;
  logic signed [DATA_W-1:0] mem_q [OUT_CH][OUT_H][OUT_W];
  logic signed [DATA_W-1:0] mem_d [OUT_CH][OUT_H][OUT_W];
  logic signed [DATA_W-1:0] v;
  logic found, sel_acc, idx_ok, xfer;
  logic [PW-1:0] gnt, p;
  logic [IDX_W-1:0] sel_idx;
  logic [OC_LOG-1:0] oc;
  logic [KH_LOG-1:0] kr;
  logic [KW_LOG-1:0] kc;

  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
  endfunction

  // Round-robin grant: first requesting port at or after the pointer; only offered while accepting
  always_comb begin
    found = 1'b0;
    gnt = '0;
    p = '0;
    for (int i = 0; i < IN_CH; i++) begin
      p = PW'((int'(rr_q) + i) % IN_CH);
      if (!found && req_valid[p]) begin
        found = 1'b1;
        gnt = p;
      end
    end
    req_ready = '0;
    if (!reset && state_q == ACCEPT && found) req_ready[gnt] = 1'b1;
    sel_acc = req_acc[gnt];
    sel_idx = req_idx[int'(gnt)*IDX_W +: IDX_W];
    kc = sel_idx[KW_LOG-1:0];
    kr = sel_idx[KW_LOG +: KH_LOG];
    oc = sel_idx[KW_LOG+KH_LOG +: OC_LOG];
    idx_ok = int'(oc) < OUT_CH && int'(kr) < K_H && int'(kc) < K_W;
    xfer = |(req_valid & req_ready);
  end

  // Drain walk order: column fastest, then row, then channel
  always_comb begin
    ncol = col_q == CW'(OUT_W-1) ? '0 : col_q + 1'b1;
    nrow = col_q != CW'(OUT_W-1) ? row_q : row_q == RW'(OUT_H-1) ? '0 : row_q + 1'b1;
    nch = (col_q == CW'(OUT_W-1) && row_q == RW'(OUT_H-1)) ? ch_q + 1'b1 : ch_q;
  end

  // Next-state: commit a granted plane (every output target maps to an in-range source), then run the drain
  always_comb begin
    state_d = state_q;
    rr_d = xfer ? PW'((int'(gnt) + 1) % IN_CH) : rr_q;
    ch_d = ch_q;
    row_d = row_q;
    col_d = col_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    err_d = err_q | (xfer & !idx_ok);
    mem_d = mem_q;
    v = '0;
    for (int o = 0; o < OUT_CH; o++)
      for (int y = 0; y < OUT_H; y++)
        for (int x = 0; x < OUT_W; x++)
          if (xfer && idx_ok && o == int'(oc)) begin
            v = req_plane[((int'(gnt)*IN_H + y + int'(kr))*IN_W + x + int'(kc))*DATA_W +: DATA_W];
            mem_d[o][y][x] = sel_acc ? sat_add(mem_q[o][y][x], v) : v;
          end
    if (state_q == ACCEPT) begin
      if (drain_start) begin
        state_d = DRAIN;
        ch_d = '0;
        row_d = '0;
        col_d = '0;
        out_valid_d = 1'b1;
        out_last_d = TOTAL == 1;
      end
    end else if (out_valid_q && out_ready) begin
      mem_d[ch_q][row_q][col_q] = '0;
      state_d = out_last_q ? ACCEPT : DRAIN;
      out_valid_d = !out_last_q;
      ch_d = nch;
      row_d = nrow;
      col_d = ncol;
      out_last_d = !out_last_q && nch == OC_LOG'(OUT_CH-1) && nrow == RW'(OUT_H-1) && ncol == CW'(OUT_W-1);
    end
  end

  // State, storage and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCEPT;
      rr_q <= '0;
      ch_q <= '0;
      row_q <= '0;
      col_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      err_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      ch_q <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end

  assign busy = state_q == DRAIN;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign out_ch = ch_q;
  assign out_row = row_q;
  assign out_col = col_q;
  assign out_data = mem_q[ch_q][row_q][col_q];
  assign err = err_q;
endmodule

// File: tb/tb_output_accum_buffer.sv
// tb_output_accum_buffer: randomized bench against an array-level model of the output map store
module tb_output_accum_buffer;
  localparam int IN_CH = 2, OUT_CH = 4, IN_H = 6, IN_W = 6, K_H = 3, K_W = 3, DATA_W = 16;
  localparam int KW_LOG = 2, KH_LOG = 2, OC_LOG = 2, IDX_W = 6;
  localparam int OUT_H = IN_H - K_H + 1, OUT_W = IN_W - K_W + 1;
  localparam int RW = $clog2(OUT_H), CW = $clog2(OUT_W);
  localparam int TOTAL = OUT_CH * OUT_H * OUT_W;
  localparam int SMAX = 2**(DATA_W-1) - 1, SMIN = -(2**(DATA_W-1));

  logic clock = 1'b0, reset = 1'b1;
  logic [IN_CH-1:0] req_valid, req_ready, req_acc;
  logic [IN_CH*IDX_W-1:0] req_idx;
  logic [IN_CH*IN_H*IN_W*DATA_W-1:0] req_plane;
  logic drain_start, busy, out_valid, out_ready, out_last, err;
  logic [DATA_W-1:0] out_data;
  logic [OC_LOG-1:0] out_ch;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  output_accum_buffer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_acc(req_acc),
    .req_idx(req_idx), .req_plane(req_plane), .drain_start(drain_start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int mdl [OUT_CH][OUT_H][OUT_W];
  int pl [IN_CH][IN_H][IN_W];
  int acc_p [IN_CH], oc_p [IN_CH], kr_p [IN_CH], kc_p [IN_CH];
  int rr_m = 0;
  bit err_m = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int s);
    return s > SMAX ? SMAX : s < SMIN ? SMIN : s;
  endfunction

  task automatic clear_model();
    foreach (mdl[o, y, x]) mdl[o][y][x] = 0;
  endtask

  task automatic clear_planes();
    foreach (pl[q, r, c]) pl[q][r][c] = 0;
  endtask

  task automatic set_port(input int q, input int acc, input int oc, input int kr, input int kc);
    acc_p[q] = acc; oc_p[q] = oc; kr_p[q] = kr; kc_p[q] = kc;
  endtask

  task automatic apply(input int q);
    if (oc_p[q] >= OUT_CH || kr_p[q] >= K_H || kc_p[q] >= K_W) err_m = 1;
    else
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++) begin
          int tr, tc;
          tr = r - kr_p[q];
          tc = c - kc_p[q];
          if (tr >= 0 && tc >= 0 && tr < OUT_H && tc < OUT_W)
            mdl[oc_p[q]][tr][tc] = acc_p[q] != 0 ? sat(mdl[oc_p[q]][tr][tc] + pl[q][r][c]) : pl[q][r][c];
        end
  endtask

  task automatic pack();
    for (int q = 0; q < IN_CH; q++) begin
      req_acc[q] = acc_p[q][0];
      req_idx[q*IDX_W +: IDX_W] = {OC_LOG'(oc_p[q]), KH_LOG'(kr_p[q]), KW_LOG'(kc_p[q])};
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          req_plane[((q*IN_H + r)*IN_W + c)*DATA_W +: DATA_W] = DATA_W'(pl[q][r][c]);
    end
  endtask

  task automatic step(input logic [IN_CH-1:0] m, input logic ds);
    int g;
    logic [IN_CH-1:0] em;
    @(negedge clock);
    pack();
    req_valid = m;
    drain_start = ds;
    #1;
    g = -1;
    for (int i = 0; i < IN_CH; i++)
      if (g < 0 && m[(rr_m + i) % IN_CH]) g = (rr_m + i) % IN_CH;
    em = '0;
    if (g >= 0) em[g] = 1'b1;
    check("grant", req_ready, em);
    check("busy_accept", busy, 0);
    @(posedge clock);
    if (g >= 0) begin
      apply(g);
      rr_m = (g + 1) % IN_CH;
    end
  endtask

  task automatic drain(input logic [IN_CH-1:0] m, input int mode, input int abort_at);
    int e, cyc, ch, r, c;
    bit aborted;
    step(m, 1'b1);
    e = 0; cyc = 0; aborted = 0;
    while (e < TOTAL && cyc < 20*TOTAL && !aborted) begin
      @(negedge clock);
      cyc++;
      if (e == abort_at) begin
        reset = 1'b1; out_ready = 1'b0; drain_start = 1'b0; req_valid = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("valid_after_reset", out_valid, 0);
        check("busy_after_reset", busy, 0);
        check("err_after_reset", err, 0);
        clear_model();
        rr_m = 0; err_m = 0; aborted = 1;
      end else begin
        out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
        req_valid = IN_CH'($urandom);
        drain_start = 1'($urandom);
        #1;
        ch = e / (OUT_H*OUT_W); r = (e / OUT_W) % OUT_H; c = e % OUT_W;
        check("valid", out_valid, 1);
        check("busy", busy, 1);
        check("ready_in_drain", req_ready, 0);
        check("ch", out_ch, ch);
        check("row", out_row, r);
        check("col", out_col, c);
        check("data", $signed(out_data), mdl[ch][r][c]);
        check("last", out_last, e == TOTAL-1);
        if (out_ready) begin
          mdl[ch][r][c] = 0;
          e++;
        end
      end
    end
    if (!aborted) begin
      check("beats", e, TOTAL);
      if (mode == 0) check("cycles", cyc, TOTAL);
      @(negedge clock);
      out_ready = 1'b0; req_valid = '0; drain_start = 1'b0;
      #1;
      check("valid_end", out_valid, 0);
      check("busy_end", busy, 0);
      check("last_end", out_last, 0);
      check("err", err, err_m);
    end
  endtask

  task automatic randomize_port(input int q);
    set_port(q, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        pl[q][r][c] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2000)) - 1000;
  endtask

  initial begin
    req_valid = '1; req_acc = '0; req_idx = '0; req_plane = '0;
    drain_start = 1'b0; out_ready = 1'b0;
    clear_model();
    clear_planes();
    for (int q = 0; q < IN_CH; q++) set_port(q, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("reset_ready", req_ready, 0);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    reset = 1'b0;
    req_valid = '0;

    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) pl[0][r][c] = 10*r + c;
    set_port(0, 0, 1, 0, 0);
    step(2'b01, 1'b0);
    drain(2'b00, 0, -1);

    clear_planes();
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) pl[1][r][c] = 5;
    set_port(1, 1, 2, 2, 1);
    step(2'b10, 1'b0);
    step(2'b10, 1'b0);
    drain(2'b00, 1, -1);

    randomize_port(0);
    randomize_port(1);
    set_port(0, 0, 0, 1, 2);
    set_port(1, 0, 3, 2, 0);
    repeat (4) step(2'b11, 1'b0);
    step(2'b00, 1'b0);
    drain(2'b00, 0, -1);

    clear_planes();
    set_port(0, 1, 0, 0, 0);
    set_port(1, 1, 3, 0, 0);
    pl[0][0][0] = 32'h7FF0;
    step(2'b01, 1'b0);
    pl[0][0][0] = 32'h0020;
    step(2'b01, 1'b0);
    pl[1][1][1] = -32752;
    step(2'b10, 1'b0);
    drain(2'b10, 2, -1);

    randomize_port(0);
    set_port(0, 0, 3, 0, 3);
    step(2'b01, 1'b0);
    drain(2'b00, 0, -1);
    drain(2'b00, 0, -1);

    randomize_port(0);
    randomize_port(1);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 1, 2, 1, 1);
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    drain(2'b00, 2, 20);
    drain(2'b00, 0, -1);

    repeat (6) begin
      repeat ($urandom_range(2, 6)) begin
        randomize_port(0);
        randomize_port(1);
        step(IN_CH'($urandom), 1'b0);
      end
      randomize_port(0);
      randomize_port(1);
      drain(IN_CH'($urandom), 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
